// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one decoded load/store at a time over a single-outstanding
// addr_ok/data_ok bus and returns extended load data or an address-error result.
typedef struct packed {
    logic        valid;
    logic        write;
    logic        sig;
    logic [1:0]  msize;
    logic [31:0] data;
} memory_args_t;

module mem_access_ctrl (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  memory_args_t args,
    input  logic [31:0]  addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  rdata,
    output logic         adel,
    output logic         ades,
    output logic [31:0]  badvaddr,
    input  logic         flush,
    output logic         dreq_valid,
    output logic [31:0]  dreq_addr,
    output logic         dreq_write,
    output logic [3:0]   dreq_strobe,
    output logic [31:0]  dreq_wdata,
    input  logic         dresp_addr_ok,
    input  logic         dresp_data_ok,
    input  logic [31:0]  dresp_rdata
);
    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q;
    logic        orphan_q;
    logic        sig_q;
    logic [1:0]  msize_q;
    logic [1:0]  off_q;
    logic [31:0] dreq_addr_q;
    logic        dreq_write_q;
    logic [3:0]  dreq_strobe_q;
    logic [31:0] dreq_wdata_q;
    logic [31:0] rdata_q;
    logic        adel_q;
    logic        ades_q;
    logic [31:0] badvaddr_q;

    logic        misalign_c;
    logic [3:0]  strobe_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted_c;
    logic [31:0] load_c;
    logic        drop_c;

    // Alignment check, byte strobes and lane-replicated store data for the op on offer
    always_comb begin
        misalign_c = ((args.msize == MSIZE2) && addr[0]) ||
                     ((args.msize == MSIZE4) && (addr[1:0] != 2'b00));
        strobe_c   = 4'h0;
        wdata_c    = args.data;
        case (args.msize)
            MSIZE1: begin
                if (args.write) strobe_c = 4'b0001 << addr[1:0];
                wdata_c = {4{args.data[7:0]}};
            end
            MSIZE2: begin
                if (args.write) strobe_c = 4'b0011 << addr[1:0];
                wdata_c = {2{args.data[15:0]}};
            end
            default: begin
                if (args.write) strobe_c = 4'hF;
            end
        endcase
    end

    // Extract the addressed lane of the returned word and extend it
    always_comb begin
        shifted_c = dresp_rdata >> {off_q, 3'b000};
        load_c    = dresp_rdata;
        case (msize_q)
            MSIZE1:  load_c = sig_q ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                    : {24'h0, shifted_c[7:0]};
            MSIZE2:  load_c = sig_q ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                    : {16'h0, shifted_c[15:0]};
            default: load_c = dresp_rdata;
        endcase
    end

    // A response belongs to a killed op if a flush arrived earlier or arrives now
    assign drop_c = orphan_q | flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            orphan_q      <= 1'b0;
            sig_q         <= 1'b0;
            msize_q       <= 2'b00;
            off_q         <= 2'b00;
            dreq_addr_q   <= 32'h0;
            dreq_write_q  <= 1'b0;
            dreq_strobe_q <= 4'h0;
            dreq_wdata_q  <= 32'h0;
            rdata_q       <= 32'h0;
            adel_q        <= 1'b0;
            ades_q        <= 1'b0;
            badvaddr_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        rdata_q    <= 32'h0;
                        adel_q     <= 1'b0;
                        ades_q     <= 1'b0;
                        badvaddr_q <= 32'h0;
                        if (!args.valid) begin
                            state_q <= DONE;
                        end else if (misalign_c) begin
                            adel_q     <= !args.write;
                            ades_q     <= args.write;
                            badvaddr_q <= addr;
                            state_q    <= DONE;
                        end else begin
                            sig_q         <= args.sig;
                            msize_q       <= args.msize;
                            off_q         <= addr[1:0];
                            dreq_addr_q   <= {addr[31:2], 2'b00};
                            dreq_write_q  <= args.write;
                            dreq_strobe_q <= strobe_c;
                            dreq_wdata_q  <= wdata_c;
                            state_q       <= REQ;
                        end
                    end
                end
                REQ: begin
                    // The request is never withdrawn; a flush only orphans it
                    if (flush) orphan_q <= 1'b1;
                    if (dresp_addr_ok) begin
                        if (dresp_data_ok) begin
                            if (drop_c) begin
                                orphan_q <= 1'b0;
                                state_q  <= IDLE;
                            end else begin
                                rdata_q <= dreq_write_q ? 32'h0 : load_c;
                                state_q <= DONE;
                            end
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) orphan_q <= 1'b1;
                    if (dresp_data_ok) begin
                        if (drop_c) begin
                            orphan_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            rdata_q <= dreq_write_q ? 32'h0 : load_c;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE) && !orphan_q;
    assign out_valid   = (state_q == DONE);
    assign dreq_valid  = (state_q == REQ);
    assign dreq_addr   = dreq_addr_q;
    assign dreq_write  = dreq_write_q;
    assign dreq_strobe = dreq_strobe_q;
    assign dreq_wdata  = dreq_wdata_q;
    assign rdata       = rdata_q;
    assign adel        = adel_q;
    assign ades        = ades_q;
    assign badvaddr    = badvaddr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] args_v;
    logic [31:0] addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
    logic        flush;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic        dreq_write;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_wdata;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    mem_access_ctrl dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .args(args_v), .addr(addr), .out_valid(out_valid), .out_ready(out_ready),
        .rdata(rdata), .adel(adel), .ades(ades), .badvaddr(badvaddr), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
        .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_rdata(dresp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    // {valid, write, sig, msize, data}; msize 0=byte 1=half 2=word
    function automatic logic [36:0] mk(input logic w, input logic s,
                                       input logic [1:0] sz, input logic [31:0] d);
        return {1'b1, w, s, sz, d};
    endfunction

    task automatic bus_op(input string tag, input logic [36:0] a, input logic [31:0] ad,
                          input int n_addr, input int m_data, input logic [31:0] word,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        logic [31:0] exp_addr;
        exp_addr = ad & 32'hFFFF_FFFC;
        in_valid = 1'b1; args_v = a; addr = ad;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        wait_clk();
        in_valid = 1'b0;
        for (int i = 0; i <= n_addr; i++) begin
            check({tag, "_req_valid"}, 32'(dreq_valid), 32'd1);
            check({tag, "_req_addr"}, dreq_addr, exp_addr);
            check({tag, "_req_strobe"}, 32'(dreq_strobe), 32'(exp_strb));
            check({tag, "_req_write"}, 32'(dreq_write), 32'(a[35]));
            if (a[35]) check({tag, "_req_wdata"}, dreq_wdata, exp_wd);
            check({tag, "_out_valid_req"}, 32'(out_valid), 32'd0);
            if (i == n_addr) begin
                dresp_addr_ok = 1'b1;
                if (m_data == 0) begin dresp_data_ok = 1'b1; dresp_rdata = word; end
            end
            wait_clk();
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        if (m_data > 0) begin
            for (int i = 1; i < m_data; i++) begin
                check({tag, "_wait_req"}, 32'(dreq_valid), 32'd0);
                check({tag, "_wait_out"}, 32'(out_valid), 32'd0);
                wait_clk();
            end
            dresp_data_ok = 1'b1; dresp_rdata = word;
            wait_clk();
            dresp_data_ok = 1'b0;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_adel"}, 32'(adel), 32'd0);
        check({tag, "_ades"}, 32'(ades), 32'd0);
        out_ready = 1'b1;
        wait_clk();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    task automatic exc_op(input string tag, input logic [36:0] a, input logic [31:0] ad,
                          input logic exp_adel, input logic exp_ades);
        in_valid = 1'b1; args_v = a; addr = ad;
        wait_clk();
        in_valid = 1'b0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_no_req"}, 32'(dreq_valid), 32'd0);
        check({tag, "_adel"}, 32'(adel), 32'(exp_adel));
        check({tag, "_ades"}, 32'(ades), 32'(exp_ades));
        check({tag, "_badvaddr"}, badvaddr, ad);
        check({tag, "_rdata"}, rdata, 32'h0);
        out_ready = 1'b1;
        wait_clk();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; args_v = '0; addr = '0; out_ready = 1'b0;
        flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        check("rst_dreq_addr", dreq_addr, 32'h0);
        check("rst_dreq_strobe", 32'(dreq_strobe), 32'h0);
        check("rst_dreq_wdata", dreq_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_adel_ades", 32'({adel, ades}), 32'h0);
        check("rst_badvaddr", badvaddr, 32'h0);
        resetn = 1'b1;
        wait_clk();

        bus_op("lb",  mk(1'b0, 1'b1, 2'd0, 32'h0), 32'h1003, 0, 0, 32'h80FF_1234,
               4'h0, 32'h0, 32'hFFFF_FF80);
        bus_op("lbu", mk(1'b0, 1'b0, 2'd0, 32'h0), 32'h1003, 0, 0, 32'h80FF_1234,
               4'h0, 32'h0, 32'h0000_0080);
        bus_op("sh",  mk(1'b1, 1'b0, 2'd1, 32'h0000_BEEF), 32'h2002, 0, 0, 32'h1111_2222,
               4'b1100, 32'hBEEF_BEEF, 32'h0);
        bus_op("lw_slow", mk(1'b0, 1'b0, 2'd2, 32'h0), 32'h4000, 3, 2, 32'hDEAD_BEEF,
               4'h0, 32'h0, 32'hDEAD_BEEF);
        bus_op("lh", mk(1'b0, 1'b1, 2'd1, 32'h0), 32'h2002, 1, 1, 32'h8001_0000,
               4'h0, 32'h0, 32'hFFFF_8001);
        bus_op("sw", mk(1'b1, 1'b0, 2'd2, 32'h1234_5678), 32'h0100, 0, 1, 32'h0,
               4'hF, 32'h1234_5678, 32'h0);

        exc_op("lw_mis", mk(1'b0, 1'b0, 2'd2, 32'h0), 32'h3001, 1'b1, 1'b0);
        exc_op("sw_mis", mk(1'b1, 1'b0, 2'd2, 32'h0), 32'h3002, 1'b0, 1'b1);
        exc_op("sh_mis", mk(1'b1, 1'b0, 2'd1, 32'h0), 32'h3001, 1'b0, 1'b1);

        // Non-memory op passes through in one cycle with zero data
        in_valid = 1'b1; args_v = 37'h0; addr = 32'h9999;
        wait_clk();
        in_valid = 1'b0;
        check("pass_out_valid", 32'(out_valid), 32'd1);
        check("pass_rdata", rdata, 32'h0);
        check("pass_no_req", 32'(dreq_valid), 32'd0);
        // Flush while the result waits: dropped
        flush = 1'b1;
        wait_clk();
        flush = 1'b0;
        check("flush_done_out", 32'(out_valid), 32'd0);
        check("flush_done_ready", 32'(in_ready), 32'd1);

        // Flush beats in_valid in the same cycle
        in_valid = 1'b1; flush = 1'b1; args_v = mk(1'b0, 1'b0, 2'd2, 32'h0); addr = 32'h0;
        wait_clk();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_req", 32'(dreq_valid), 32'd0);
        check("flush_idle_out", 32'(out_valid), 32'd0);
        check("flush_idle_ready", 32'(in_ready), 32'd1);

        // Flush in second REQ cycle of LHU 0x5000
        in_valid = 1'b1; args_v = mk(1'b0, 1'b0, 2'd1, 32'h0); addr = 32'h5000;
        wait_clk();
        in_valid = 1'b0;
        check("orph_req1", 32'(dreq_valid), 32'd1);
        wait_clk();
        flush = 1'b1;
        check("orph_req2", 32'(dreq_valid), 32'd1);
        wait_clk();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("orph_hold_valid", 32'(dreq_valid), 32'd1);
            check("orph_hold_addr", dreq_addr, 32'h5000);
            check("orph_hold_ready", 32'(in_ready), 32'd0);
            if (i == 1) dresp_addr_ok = 1'b1;
            wait_clk();
        end
        dresp_addr_ok = 1'b0;
        check("orph_wait_req", 32'(dreq_valid), 32'd0);
        check("orph_wait_ready", 32'(in_ready), 32'd0);
        check("orph_wait_out", 32'(out_valid), 32'd0);
        dresp_data_ok = 1'b1; dresp_rdata = 32'hCAFE_F00D;
        wait_clk();
        dresp_data_ok = 1'b0;
        check("orph_drop_out", 32'(out_valid), 32'd0);
        check("orph_ready_back", 32'(in_ready), 32'd1);
        bus_op("lbu_after", mk(1'b0, 1'b0, 2'd0, 32'h0), 32'h5001, 0, 0, 32'h0000_AB00,
               4'h0, 32'h0, 32'h0000_00AB);

        // Asynchronous reset in the middle of a WAIT
        in_valid = 1'b1; args_v = mk(1'b0, 1'b0, 2'd2, 32'h0); addr = 32'h7000;
        wait_clk();
        in_valid = 1'b0;
        dresp_addr_ok = 1'b1;
        wait_clk();
        dresp_addr_ok = 1'b0;
        check("wait_before_rst", 32'(dreq_addr), 32'h7000);
        #2 resetn = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_dreq_valid", 32'(dreq_valid), 32'd0);
        check("arst_dreq_addr", dreq_addr, 32'h0);
        check("arst_rdata", rdata, 32'h0);
        #2 resetn = 1'b1;
        wait_clk();
        bus_op("sb", mk(1'b1, 1'b0, 2'd0, 32'h0000_0055), 32'h6001, 0, 0, 32'h0,
               4'b0010, 32'h5555_5555, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
